// File: rtl/configurable_logic_element.sv
// K-input logic element: 2^K-bit LUT, serial config chain, optional
// output register, fracturable into two (K-1)-input LUTs.
//
// Ports:
//   clk      fabric clock, rising edge
//   rst      asynchronous active-high reset
//   cfg_en   shift the config chain this cycle; outputs forced to 0
//   cfg_in   serial config data in
//   cfg_out  serial config data out (cfg_sr[0]) to the next element
//   ce       output register clock enable (user mode only)
//   data_in  LUT inputs
//   out_a    primary output
//   out_b    secondary output (fracture mode only, else 0)
//
// Chain layout, LSB first:
//   [N-1:0] table, [N] reg_mode, [N+1] fracture, [N+2] ff_init

module configurable_logic_element #(
  parameter int K = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  input  logic         ce,
  input  logic [K-1:0] data_in,
  output logic         out_a,
  output logic         out_b
);

  localparam int N     = 2 ** K;
  localparam int CFG_W = N + 3;

  logic [CFG_W-1:0] cfg_sr;
  logic [N-1:0]     tbl;
  logic [K-2:0]     sub;
  logic             reg_mode;
  logic             fracture;
  logic             ff_init;
  logic             lut_a;
  logic             lut_b;
  logic             ff_a;
  logic             ff_b;
  logic             cfg_en_d;
  logic             cfg_done;

  assign tbl      = cfg_sr[N-1:0];
  assign reg_mode = cfg_sr[N];
  assign fracture = cfg_sr[N+1];
  assign ff_init  = cfg_sr[N+2];
  assign cfg_out  = cfg_sr[0];

  assign sub      = data_in[K-2:0];

  // Falling edge of cfg_en: the new image is complete this cycle.
  assign cfg_done = cfg_en_d & ~cfg_en;

  // Fractured: the top input bit is replaced by the half select,
  // so out_a reads the lower half and out_b the upper half.
  always_comb begin
    lut_a = tbl[data_in];
    lut_b = 1'b0;
    if (fracture) begin
      lut_a = tbl[{1'b0, sub}];
      lut_b = tbl[{1'b1, sub}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_sr   <= '0;
      cfg_en_d <= 1'b0;
      ff_a     <= 1'b0;
      ff_b     <= 1'b0;
    end else begin
      cfg_en_d <= cfg_en;
      if (cfg_en) begin
        cfg_sr <= {cfg_in, cfg_sr[CFG_W-1:1]};
      end
      if (cfg_done) begin
        ff_a <= ff_init;
        ff_b <= ff_init & fracture;
      end else if (!cfg_en && ce) begin
        ff_a <= lut_a;
        ff_b <= lut_b;
      end
    end
  end

  always_comb begin
    out_a = 1'b0;
    out_b = 1'b0;
    if (!cfg_en) begin
      if (reg_mode) begin
        out_a = ff_a;
        out_b = ff_b;
      end else begin
        out_a = lut_a;
        out_b = lut_b;
      end
    end
  end

endmodule

// File: tb/tb_configurable_logic_element.sv
// Directed bench for configurable_logic_element: single element,
// two-element daisy chain, and a K=2 build.

module tb_configurable_logic_element;

  logic       clk;
  logic       rst;

  logic       a_en;
  logic       a_in;
  logic       a_cout;
  logic       a_ce;
  logic [5:0] a_data;
  logic       a_oa;
  logic       a_ob;

  logic       c_en;
  logic       c_in;
  logic       c0_cout;
  logic       c1_cout;
  logic       c_ce;
  logic [5:0] c0_data;
  logic [5:0] c1_data;
  logic       c0_oa;
  logic       c0_ob;
  logic       c1_oa;
  logic       c1_ob;

  logic       k_en;
  logic       k_in;
  logic       k_cout;
  logic       k_ce;
  logic [1:0] k_data;
  logic       k_oa;
  logic       k_ob;

  int checks = 0;
  int errors = 0;

  localparam logic [66:0] IMG_AND6 =
    {3'b000, 64'h8000_0000_0000_0000};
  localparam logic [66:0] IMG_NOR6 =
    {3'b000, 64'h0000_0000_0000_0001};
  // ff_init=1, fracture=0, reg_mode=1, out = in[0]
  localparam logic [66:0] IMG_REG =
    {3'b101, 64'hAAAA_AAAA_AAAA_AAAA};
  // upper half OR5, lower half XOR5 (parity)
  localparam logic [66:0] IMG_FRAC =
    {3'b010, 32'hFFFF_FFFE, 32'h9669_6996};
  localparam logic [66:0] IMG_ONES = '1;
  localparam logic [6:0]  IMG_XOR2 = {3'b000, 4'b0110};

  configurable_logic_element #(.K(6)) u_a (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (a_en),
    .cfg_in  (a_in),
    .cfg_out (a_cout),
    .ce      (a_ce),
    .data_in (a_data),
    .out_a   (a_oa),
    .out_b   (a_ob)
  );

  configurable_logic_element #(.K(6)) u_c0 (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (c_en),
    .cfg_in  (c_in),
    .cfg_out (c0_cout),
    .ce      (c_ce),
    .data_in (c0_data),
    .out_a   (c0_oa),
    .out_b   (c0_ob)
  );

  configurable_logic_element #(.K(6)) u_c1 (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (c_en),
    .cfg_in  (c0_cout),
    .cfg_out (c1_cout),
    .ce      (c_ce),
    .data_in (c1_data),
    .out_a   (c1_oa),
    .out_b   (c1_ob)
  );

  configurable_logic_element #(.K(2)) u_k (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (k_en),
    .cfg_in  (k_in),
    .cfg_out (k_cout),
    .ce      (k_ce),
    .data_in (k_data),
    .out_a   (k_oa),
    .out_b   (k_ob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Bit 0 goes in first and ends at cfg_sr[0].
  task automatic load_a(input logic [66:0] img);
    for (int i = 0; i < 67; i++) begin
      a_en = 1'b1;
      a_in = img[i];
      @(posedge clk);
      #1;
      if (i == 30) begin
        chk("gated_during_shift", {6'd0, a_oa, a_ob}, 8'd0);
      end
    end
    a_en = 1'b0;
    a_in = 1'b0;
  endtask

  initial begin
    logic [133:0] strm;
    logic [5:0]   v;
    logic [1:0]   w;
    logic         prev;
    logic         seen;
    int           at;
    logic [3:0]   seq;

    rst = 1'b0;
    a_en = 0; a_in = 0; a_ce = 0; a_data = '0;
    c_en = 0; c_in = 0; c_ce = 0;
    c0_data = '0; c1_data = '0;
    k_en = 0; k_in = 0; k_ce = 0; k_data = '0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outs", {5'd0, a_oa, a_ob, a_cout}, 8'd0);
    rst = 1'b0;

    // 1: AND6, combinational
    a_data = 6'h3F;
    load_a(IMG_AND6);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = 6'(i);
      a_data = v;
      #1;
      chk($sformatf("and6_%0d", i),
          {6'd0, a_oa, a_ob}, {6'd0, (v == 6'h3F), 1'b0});
    end

    // 2: registered mode, reconfigured without reset
    a_data = 6'h3F;
    load_a(IMG_REG);
    a_ce = 1'b1;
    a_data = 6'h00;
    @(posedge clk);
    #1;
    chk("reg_ff_init", {7'd0, a_oa}, 8'd1);
    prev = 1'b1;
    seq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      a_data = {5'd0, seq[i]};
      #1;
      chk($sformatf("reg_lag_%0d", i), {7'd0, a_oa}, {7'd0, prev});
      @(posedge clk);
      #1;
      chk($sformatf("reg_follow_%0d", i),
          {7'd0, a_oa}, {7'd0, seq[i]});
      prev = seq[i];
    end
    a_ce = 1'b0;
    a_data = 6'h00;
    @(posedge clk);
    #1;
    chk("reg_hold_ce0", {6'd0, a_oa, a_ob}, 8'b10);

    // 3: fracture, bit5 ignored
    load_a(IMG_FRAC);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = 6'(i);
      a_data = v;
      #1;
      chk($sformatf("frac_%0d", i), {6'd0, a_oa, a_ob},
          {6'd0, ^v[4:0], |v[4:0]});
    end

    // registered fracture: both outputs take ff_init
    load_a(IMG_ONES);
    chk("ones_before_done", {6'd0, a_oa, a_ob}, 8'd0);
    @(posedge clk);
    #1;
    chk("ones_ff_init_ab", {6'd0, a_oa, a_ob}, 8'b11);

    // 5: async reset after 30 shifts
    for (int i = 0; i < 30; i++) begin
      a_en = 1'b1;
      a_in = IMG_AND6[i];
      @(posedge clk);
      #1;
    end
    chk("pre_rst_cfg_out", {7'd0, a_cout}, 8'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outs", {5'd0, a_oa, a_ob, a_cout}, 8'd0);
    a_en = 1'b0;
    a_data = 6'h3F;
    #1;
    chk("rst_cfg_cleared", {5'd0, a_oa, a_ob, a_cout}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {5'd0, a_oa, a_ob, a_cout}, 8'd0);
    load_a(IMG_AND6);
    a_data = 6'h3F;
    #1 chk("reload_3f", {6'd0, a_oa, a_ob}, 8'b10);
    a_data = 6'h3E;
    #1 chk("reload_3e", {6'd0, a_oa, a_ob}, 8'b00);
    a_data = 6'h1F;
    #1 chk("reload_1f", {6'd0, a_oa, a_ob}, 8'b00);

    // 4: daisy chain, first 67 bits end in the second element
    strm = {IMG_AND6, IMG_NOR6};
    seen = 1'b0;
    at = 0;
    for (int n = 1; n <= 134; n++) begin
      c_en = 1'b1;
      c_in = strm[n-1];
      @(posedge clk);
      #1;
      if (!seen && c1_cout) begin
        seen = 1'b1;
        at = n;
      end
    end
    c_en = 1'b0;
    c_in = 1'b0;
    chk("chain_marker_shift", 8'(at), 8'd134);
    chk("chain_cfg_outs", {6'd0, c0_cout, c1_cout}, 8'b01);
    c0_data = 6'h3F;
    c1_data = 6'h00;
    #1;
    chk("chain_c0_3f", {6'd0, c0_oa, c0_ob}, 8'b10);
    chk("chain_c1_00", {6'd0, c1_oa, c1_ob}, 8'b10);
    c0_data = 6'h00;
    c1_data = 6'h3F;
    #1;
    chk("chain_c0_00", {6'd0, c0_oa, c0_ob}, 8'b00);
    chk("chain_c1_3f", {6'd0, c1_oa, c1_ob}, 8'b00);

    // 6: K=2 build, XOR2
    for (int i = 0; i < 7; i++) begin
      k_en = 1'b1;
      k_in = IMG_XOR2[i];
      @(posedge clk);
      #1;
    end
    k_en = 1'b0;
    k_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = 2'(i);
      k_data = w;
      #1;
      chk($sformatf("k2_xor_%0d", i), {5'd0, k_oa, k_ob, k_cout},
          {5'd0, w[0] ^ w[1], 2'b00});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
